// File: rtl/gf251_pkg.sv
// Shared GF(251) constants, FSM state type and canonicalising helper for the
// packed 4-lane multiply-accumulate slice.
package gf251_pkg;

  localparam int unsigned GF251_Q      = 251;
  localparam int unsigned GF251_LANE_W = 8;
  localparam int unsigned GF251_LANES  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } gf251_state_e;

  // Folds the non-canonical byte values 251..255 back into 0..4.
  function automatic logic [GF251_LANE_W-1:0] gf251_canon(input logic [GF251_LANE_W-1:0] b);
    if (b >= GF251_LANE_W'(GF251_Q))
      return b - GF251_LANE_W'(GF251_Q);
    else
      return b;
  endfunction

endpackage

// File: rtl/gf251_add_lane.sv
// One GF(251) lane: pre-reduce the incoming byte, then add modulo 251.
// acc_i must already be canonical (0..250); sum_o is always canonical.
module gf251_add_lane
  import gf251_pkg::*;
(
  input  logic [GF251_LANE_W-1:0] acc_i,
  input  logic [GF251_LANE_W-1:0] d_i,
  output logic [GF251_LANE_W-1:0] sum_o
);

  logic [GF251_LANE_W:0] s;

  always_comb begin
    s = {1'b0, acc_i} + {1'b0, gf251_canon(d_i)};
    if (s >= (GF251_LANE_W + 1)'(GF251_Q))
      sum_o = GF251_LANE_W'(s - (GF251_LANE_W + 1)'(GF251_Q));
    else
      sum_o = s[GF251_LANE_W-1:0];
  end

endmodule

// File: rtl/gf251_mac_acc_32.sv
// Four-lane GF(251) accumulator: sums N_TERMS packed product beats per lane.
// Optional horizontal lane sum on o_hsum when GF251_MAC_HSUM_EN is defined.
module gf251_mac_acc_32
  import gf251_pkg::*;
#(
  parameter int unsigned N_TERMS = 16,
  parameter int unsigned LANES   = 4,
  parameter int unsigned CNT_W   = $clog2(N_TERMS + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_valid,
  input  logic [31:0] i_data,
  output logic [31:0] o_acc,
  output logic        o_done,
  output logic        o_busy,
  output logic        o_drop,
  output logic [7:0]  o_hsum
);

  gf251_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base, cnt_inc;
  logic [31:0]      sum_q, sum_d, acc_q, acc_d, base, add_out;
  logic             done_q, done_d, drop_q, drop_d;
  logic             accept, last;

  // A start in the same cycle as a beat clears the lanes before that beat is added.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    gf251_add_lane u_add (
      .acc_i (base[GF251_LANE_W*k +: GF251_LANE_W]),
      .d_i   (i_data[GF251_LANE_W*k +: GF251_LANE_W]),
      .sum_o (add_out[GF251_LANE_W*k +: GF251_LANE_W])
    );
  end

  always_comb begin
    accept   = i_valid && ((state_q == ST_ACC) || i_start);
    base     = i_start ? '0 : sum_q;
    cnt_base = i_start ? '0 : cnt_q;
    cnt_inc  = cnt_base + CNT_W'(1);
    last     = (cnt_inc == CNT_W'(N_TERMS));

    state_d  = state_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    drop_d   = i_valid && (state_q == ST_IDLE) && !i_start;

    if (accept) begin
      if (last) begin
        acc_d   = add_out;
        done_d  = 1'b1;
        state_d = ST_IDLE;
        cnt_d   = '0;
        sum_d   = '0;
      end else begin
        sum_d   = add_out;
        cnt_d   = cnt_inc;
        state_d = ST_ACC;
      end
    end else if (i_start) begin
      sum_d   = '0;
      cnt_d   = '0;
      state_d = ST_ACC;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign o_acc  = acc_q;
  assign o_done = done_q;
  assign o_drop = drop_q;
  assign o_busy = (state_q == ST_ACC);

`ifdef GF251_MAC_HSUM_EN
  logic [7:0] h01, h23, hall, hsum_q;

  gf251_add_lane u_h01 (.acc_i(add_out[7:0]),   .d_i(add_out[15:8]),  .sum_o(h01));
  gf251_add_lane u_h23 (.acc_i(add_out[23:16]), .d_i(add_out[31:24]), .sum_o(h23));
  gf251_add_lane u_hall(.acc_i(h01),            .d_i(h23),            .sum_o(hall));

  always_ff @(posedge i_clk) begin
    if (i_rst)
      hsum_q <= '0;
    else if (done_d)
      hsum_q <= hall;
  end

  assign o_hsum = hsum_q;
`else
  assign o_hsum = 8'h00;
`endif

endmodule
